rib_dma: RTL and testbench

Word-copy bus initiator for the RIB peripheral bus: drives the same request/acknowledge interface that timer, UART and GPIO peripherals respond on, from the initiator end. On a start pulse it copies `len_i` 32-bit words from `src_i` to `dst_i`, one read and one write per word. It sits beside the core as a second RIB master behind the bus arbiter. It reports completion and timeout errors through a one-cycle done pulse and a sticky error flag.

---
 rtl/rib_dma.sv | 117 +++++++++++
 tb/tb_rib_dma.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rib_dma.sv
// RIB bus word-copy initiator: reads len words from src and writes them to dst,
// one read/write pair per word, with a per-access ack timeout.
module rib_dma #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] src_i,
  input  logic [31:0] dst_i,
  input  logic [15:0] len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] count_o,
  output logic        req_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  input  logic [31:0] data_i,
  input  logic        ack_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state, state_nx;
  logic [31:0] src_q, dst_q, buf_q;
  logic [15:0] rem_q, count_q;
  logic [7:0]  wait_q;
  logic        err_q;
  logic        timeout;

  // Limit is reached on the cycle the counter would hit MAX_WAIT; an ack in
  // that same cycle still wins.
  assign timeout = req_o && !ack_i && (wait_q == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    req_o    = 1'b0;
    we_o     = 1'b0;
    addr_o   = 32'h0;
    data_o   = 32'h0;
    done_o   = 1'b0;
    busy_o   = 1'b1;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_nx = (len_i == 16'd0) ? DONE : RD;
      end
      RD: begin
        req_o  = 1'b1;
        addr_o = src_q;
        if (ack_i)        state_nx = WR;
        else if (timeout) state_nx = DONE;
      end
      WR: begin
        req_o  = 1'b1;
        we_o   = 1'b1;
        addr_o = dst_q;
        data_o = buf_q;
        if (ack_i)        state_nx = (rem_q == 16'd1) ? DONE : RD;
        else if (timeout) state_nx = DONE;
      end
      DONE: begin
        done_o   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control registers: reset to give all-zero outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 16'd0;
      err_q   <= 1'b0;
      wait_q  <= 8'd0;
    end else begin
      if (state == IDLE && start_i) begin
        count_q <= 16'd0;
        err_q   <= 1'b0;
      end else if (state == WR && ack_i) begin
        count_q <= count_q + 16'd1;
      end else if (timeout) begin
        err_q   <= 1'b1;
      end
      if (!req_o || state_nx != state) wait_q <= 8'd0;
      else if (!ack_i)                 wait_q <= wait_q + 8'd1;
    end
  end

  // Datapath registers: only meaningful while the FSM is active.
  always_ff @(posedge clk) begin
    if (state == IDLE && start_i) begin
      src_q <= {src_i[31:2], 2'b00};
      dst_q <= {dst_i[31:2], 2'b00};
      rem_q <= len_i;
    end else if (state == RD && ack_i) begin
      buf_q <= data_i;
      src_q <= src_q + 32'd4;
    end else if (state == WR && ack_i) begin
      dst_q <= dst_q + 32'd4;
      rem_q <= rem_q - 16'd1;
    end
  end

  assign err_o   = err_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_rib_dma.sv
// Scoreboard bench for rib_dma: stimulus pushes expected bus accesses and done
// events; a negedge monitor pops and compares them as the DUT presents them.
module tb_rib_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] src_i = 32'h0, dst_i = 32'h0;
  logic [15:0] len_i = 16'h0;
  logic        busy_o, done_o, err_o, req_o, we_o;
  logic [15:0] count_o;
  logic [31:0] addr_o, data_o, data_i;
  logic        ack_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ack_mode = 0;   // 0: always ack, 1: never ack, 2: two wait cycles per access
  int wcnt    = 0;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } bus_t;
  typedef struct { int cyc; logic [15:0] count; logic err; } done_t;
  bus_t  bus_q[$];
  done_t done_q[$];

  rib_dma #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .src_i(src_i), .dst_i(dst_i),
    .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .count_o(count_o), .req_o(req_o), .we_o(we_o), .addr_o(addr_o),
    .data_o(data_o), .data_i(data_i), .ack_i(ack_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: read data is derived from the address so expectations are easy.
  assign data_i = (req_o && !we_o) ? {addr_o[15:0], 16'hBEEF} : 32'h0;
  assign ack_i  = (ack_mode == 0) ? 1'b1 :
                  (ack_mode == 1) ? 1'b0 : (req_o && wcnt == 2);
  always @(posedge clk) begin
    if (req_o && ack_i) wcnt <= 0;
    else if (req_o)     wcnt <= wcnt + 1;
    else                wcnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  logic        prev_wait = 1'b0;
  logic        prev_we;
  logic [31:0] prev_addr, prev_data;
  always @(negedge clk) begin
    if (req_o === 1'b1) begin
      if (prev_wait) begin
        chk("stable_we", {31'h0, we_o}, {31'h0, prev_we});
        chk("stable_addr", addr_o, prev_addr);
        chk("stable_data", data_o, prev_data);
      end
      if (ack_i) begin
        if (bus_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL bus_unexpected: we=%b addr=%h data=%h", we_o, addr_o, data_o);
        end else begin
          bus_t e;
          e = bus_q.pop_front();
          chk("bus_we", {31'h0, we_o}, {31'h0, e.we});
          chk("bus_addr", addr_o, e.addr);
          if (e.we) chk("bus_wdata", data_o, e.data);
        end
      end
    end
    prev_wait = (req_o === 1'b1) && !ack_i;
    prev_we = we_o; prev_addr = addr_o; prev_data = data_o;
    if (done_o === 1'b1) begin
      if (done_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL done_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        done_t d;
        d = done_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(d.cyc));
        chk("done_count", {16'h0, count_o}, {16'h0, d.count});
        chk("done_err", {31'h0, err_o}, {31'h0, d.err});
      end
    end
  end

  task automatic push_bus(input logic we, input logic [31:0] addr, input logic [31:0] data);
    bus_t e;
    e.we = we; e.addr = addr; e.data = data;
    bus_q.push_back(e);
  endtask

  task automatic push_rw(input logic [31:0] ra, input logic [31:0] wa);
    push_bus(1'b0, ra, {ra[15:0], 16'hBEEF});
    push_bus(1'b1, wa, {ra[15:0], 16'hBEEF});
  endtask

  // Returns at the negedge of cycle 1 after the start edge.
  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input bit want_done, input int k, input logic [15:0] ecount,
                          input logic eerr);
    done_t x;
    @(negedge clk);
    src_i = s; dst_i = d; len_i = n; start_i = 1'b1;
    if (want_done) begin
      x.cyc = cyc + k; x.count = ecount; x.err = eerr;
      done_q.push_back(x);
    end
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done_o === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got no done_o expected pulse", name);
    end
    @(negedge clk);
    chk({name, "_busy_after"}, {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_done", {31'h0, done_o}, 32'h0);
    chk("rst_err", {31'h0, err_o}, 32'h0);
    chk("rst_count", {16'h0, count_o}, 32'h0);
    chk("rst_req", {31'h0, req_o}, 32'h0);
    chk("rst_we", {31'h0, we_o}, 32'h0);
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_data", data_o, 32'h0);
    rst = 1'b0;

    // 3-word copy, ack always high
    ack_mode = 0;
    push_rw(32'h100, 32'h200); push_rw(32'h104, 32'h204); push_rw(32'h108, 32'h208);
    do_start(32'h100, 32'h200, 16'd3, 1'b1, 7, 16'd3, 1'b0);
    chk("copy3_busy", {31'h0, busy_o}, 32'h1);
    chk("copy3_first_req", {31'h0, req_o}, 32'h1);
    wait_done("copy3");
    chk("copy3_count", {16'h0, count_o}, 32'd3);

    // Zero length
    do_start(32'h100, 32'h200, 16'd0, 1'b1, 1, 16'd0, 1'b0);
    chk("zero_req", {31'h0, req_o}, 32'h0);
    wait_done("zero");

    // Two wait cycles per access, one word
    ack_mode = 2;
    push_rw(32'h1000, 32'h2000);
    do_start(32'h1000, 32'h2000, 16'd1, 1'b1, 7, 16'd1, 1'b0);
    wait_done("wait2");

    // Timeout with ack tied low
    ack_mode = 1;
    do_start(32'h400, 32'h480, 16'd1, 1'b1, 5, 16'd0, 1'b1);
    wait_done("tmo");
    chk("tmo_err_sticky", {31'h0, err_o}, 32'h1);
    ack_mode = 0;
    push_rw(32'h500, 32'h600);
    do_start(32'h500, 32'h600, 16'd1, 1'b1, 3, 16'd1, 1'b0);
    chk("tmo_err_cleared", {31'h0, err_o}, 32'h0);
    wait_done("after_tmo");

    // Address wrap
    push_rw(32'hFFFF_FFFC, 32'h300); push_rw(32'h0, 32'h304);
    do_start(32'hFFFF_FFFC, 32'h300, 16'd2, 1'b1, 5, 16'd2, 1'b0);
    wait_done("wrap");

    // Unaligned inputs and a start pulse mid-transfer
    push_rw(32'h700, 32'h800); push_rw(32'h704, 32'h804);
    do_start(32'h703, 32'h801, 16'd2, 1'b1, 5, 16'd2, 1'b0);
    src_i = 32'hF00; dst_i = 32'hF80; len_i = 16'd5; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done("midstart");
    chk("midstart_count", {16'h0, count_o}, 32'd2);

    // Reset asserted while in WR
    push_rw(32'h900, 32'hA00);
    do_start(32'h900, 32'hA00, 16'd3, 1'b0, 0, 16'd0, 1'b0);
    @(negedge clk);
    chk("rstwr_in_wr", {31'h0, we_o}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstwr_req", {31'h0, req_o}, 32'h0);
    chk("rstwr_we", {31'h0, we_o}, 32'h0);
    chk("rstwr_addr", addr_o, 32'h0);
    chk("rstwr_data", data_o, 32'h0);
    chk("rstwr_busy", {31'h0, busy_o}, 32'h0);
    chk("rstwr_count", {16'h0, count_o}, 32'h0);
    chk("rstwr_err", {31'h0, err_o}, 32'h0);
    repeat (6) @(negedge clk);

    chk("bus_queue_empty", 32'(bus_q.size()), 32'h0);
    chk("done_queue_empty", 32'(done_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
